ram_byte_streamer: RTL

- Read-only drain engine on the second port of the shared data RAM.
- After the CPU finishes JPEG encoding, this block fetches the encoded bitstream words from RAM and unpacks them into a little-endian byte stream.
- The byte stream uses a valid/ready handshake and feeds the downstream byte sink (UART/host link).
- Software starts a transfer with a base word address and a byte count, then polls busy/done/error.

---
 rtl/ram_byte_streamer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ram_byte_streamer.sv
// ram_byte_streamer: read-only drain engine on the second RAM port.
// Fetches encoded bitstream words from RAM and emits them as a
// little-endian byte stream over a valid/ready handshake. Software starts
// a transfer with a word address and byte count, then polls busy/done/error.
module ram_byte_streamer #(
  parameter int WIDTH = 32,
  parameter int BASE  = 206800,
  parameter int DEPTH = 206800,
  parameter int LEN_W = 20
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [LEN_W-1:0] byte_len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] ram_address,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             ram_enw,
  output logic [WIDTH-1:0] ram_wdata,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  // Address window, one bit wider than the address so the +1 past the
  // last word cannot wrap around and look valid.
  localparam logic [WIDTH:0] LP_FIRST = (WIDTH + 1)'(BASE);
  localparam logic [WIDTH:0] LP_LAST  = (WIDTH + 1)'(BASE + DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_FIN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Little-endian byte lane select: lane 0 is bits 7:0.
  function automatic logic [7:0] byte_sel(input logic [WIDTH-1:0] word,
                                          input logic [1:0]       idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_ram_addr;
  logic [WIDTH-1:0] r_word;
  logic [1:0]       r_idx;
  logic [LEN_W-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic             r_valid;
  logic [7:0]       r_data;

  state_t           w_next_state;
  logic [WIDTH-1:0] w_addr_n;
  logic [WIDTH-1:0] w_ram_addr_n;
  logic [WIDTH-1:0] w_word_n;
  logic [1:0]       w_idx_n;
  logic [LEN_W-1:0] w_rem_n;
  logic [7:0]       w_data_n;

  logic             w_hs;
  logic [LEN_W-1:0] w_rem_dec;
  logic [WIDTH:0]   w_addr_ext;
  logic [WIDTH:0]   w_addr_inc;
  logic [1:0]       w_idx_inc;

  assign w_hs       = r_valid & out_ready;
  assign w_rem_dec  = r_rem - LEN_W'(1);
  assign w_addr_ext = {1'b0, r_addr};
  assign w_addr_inc = {1'b0, r_addr} + (WIDTH + 1)'(1);
  assign w_idx_inc  = r_idx + 2'd1;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath-update decode.
  always_comb begin
    w_next_state = r_state;
    w_addr_n     = r_addr;
    w_ram_addr_n = r_ram_addr;
    w_word_n     = r_word;
    w_idx_n      = r_idx;
    w_rem_n      = r_rem;
    w_data_n     = r_data;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_CHECK;
          w_addr_n     = base_addr;
          w_rem_n      = byte_len;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CHECK: begin
        if (r_rem == '0) begin
          w_next_state = S_FIN;
        end else if ((w_addr_ext < LP_FIRST) || (w_addr_ext > LP_LAST)) begin
          w_next_state = S_ERR;
        end else begin
          w_next_state = S_FETCH;
          w_ram_addr_n = r_addr;
        end
      end
      S_FETCH: begin
        // ram_address already presents r_addr; capture the word and lane 0.
        w_word_n     = ram_rdata;
        w_idx_n      = 2'd0;
        w_data_n     = byte_sel(ram_rdata, 2'd0);
        w_next_state = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          w_rem_n = w_rem_dec;
          if (w_rem_dec == '0) begin
            w_next_state = S_FIN;
          end else if (r_idx == 2'd3) begin
            w_addr_n = w_addr_inc[WIDTH-1:0];
            if (w_addr_inc > LP_LAST) begin
              w_next_state = S_ERR;
            end else begin
              w_next_state = S_FETCH;
              w_ram_addr_n = w_addr_inc[WIDTH-1:0];
            end
          end else begin
            w_idx_n      = w_idx_inc;
            w_data_n     = byte_sel(r_word, w_idx_inc);
            w_next_state = S_SEND;
          end
        end else begin
          // Stalled: hold the presented byte.
          w_next_state = S_SEND;
        end
      end
      S_FIN: begin
        w_next_state = S_IDLE;
      end
      S_ERR: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath registers: word address, RAM address, buffer, index, count, byte.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_addr     <= '0;
      r_ram_addr <= WIDTH'(BASE);
      r_word     <= '0;
      r_idx      <= 2'd0;
      r_rem      <= '0;
      r_data     <= 8'h00;
    end else begin
      r_addr     <= w_addr_n;
      r_ram_addr <= w_ram_addr_n;
      r_word     <= w_word_n;
      r_idx      <= w_idx_n;
      r_rem      <= w_rem_n;
      r_data     <= w_data_n;
    end
  end

  // Registered status and stream-valid flags, decoded from the next state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (w_next_state == S_FIN);
      r_error <= (w_next_state == S_ERR);
      r_valid <= (w_next_state == S_SEND);
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign ram_address = r_ram_addr;
  assign ram_enw     = 1'b0;
  assign ram_wdata   = '0;

endmodule
